// File: rtl/ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module      : ecc_scrubber
// Description : Background scrubber for one SECDED (39,32) SRAM bank; reads,
//               corrects and writes back one word per trigger, core first.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_scrubber #(
    parameter  int BANK_SIZE  = 256,
    localparam int ADDR_WIDTH = $clog2(BANK_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  scrub_trigger_i,
    input  logic                  intc_req_i,
    input  logic                  intc_we_i,
    input  logic [ADDR_WIDTH-1:0] intc_addr_i,
    output logic                  scrub_req_o,
    output logic                  scrub_we_o,
    output logic [ADDR_WIDTH-1:0] scrub_addr_o,
    output logic [38:0]           scrub_wdata_o,
    input  logic [38:0]           scrub_rdata_i,
    output logic                  scrub_fix_o,
    output logic                  scrub_uncorrectable_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    // Hsiao columns: the first 32 weight-3 7-bit values in ascending order.
    localparam logic [6:0] c_H_COL [32] = '{
        7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
        7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
        7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
        7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
    };

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_pending;
    logic [38:0]           r_wdata;

    logic [6:0]            w_calc;
    logic [6:0]            w_syn;
    logic [6:0]            w_chk_new;
    logic [31:0]           w_data_fix;
    logic                  w_hit;
    logic                  w_single;
    logic                  w_double;
    logic                  w_stale;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    always_comb begin
        w_calc     = '0;
        w_data_fix = scrub_rdata_i[31:0];
        w_hit      = 1'b0;
        w_chk_new  = '0;
        for (int i = 0; i < 32; i++) begin
            if (scrub_rdata_i[i]) w_calc = w_calc ^ c_H_COL[i];
        end
        w_syn = w_calc ^ scrub_rdata_i[38:32];
        for (int i = 0; i < 32; i++) begin
            if (w_syn == c_H_COL[i]) begin
                w_data_fix[i] = ~scrub_rdata_i[i];
                w_hit         = 1'b1;
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (w_data_fix[i]) w_chk_new = w_chk_new ^ c_H_COL[i];
        end
        // A lone check-bit flip is correctable too; other odd syndromes are not.
        w_single = w_hit || ((w_syn != '0) && ((w_syn & (w_syn - 7'd1)) == '0));
        w_double = (w_syn != '0) && !w_single;
    end

    assign w_stale     = intc_req_i & intc_we_i & (intc_addr_i == r_addr);
    assign w_addr_next = (r_addr == ADDR_WIDTH'(BANK_SIZE - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

    assign scrub_req_o           = (r_state == S_READ) || (r_state == S_WRITE);
    assign scrub_we_o            = (r_state == S_WRITE);
    assign scrub_addr_o          = r_addr;
    assign scrub_wdata_o         = scrub_we_o ? r_wdata : '0;
    assign scrub_fix_o           = (r_state == S_DECODE) && w_single;
    assign scrub_uncorrectable_o = (r_state == S_DECODE) && w_double;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_pending <= 1'b0;
            r_wdata   <= '0;
        end else begin
            if (r_state != S_IDLE && scrub_trigger_i) r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (scrub_trigger_i || r_pending) begin
                        r_state   <= S_READ;
                        r_pending <= 1'b0;
                    end
                end
                S_READ: begin
                    if (!intc_req_i) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    // A core write to this word makes the corrected copy stale.
                    if (w_single && !w_stale) begin
                        r_wdata <= {w_chk_new, w_data_fix};
                        r_state <= S_WRITE;
                    end else begin
                        r_addr  <= w_addr_next;
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (w_stale || !intc_req_i) begin
                        r_addr  <= w_addr_next;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
